// File: rtl/can_bit_destuffer_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN bit destuffer: destuff FSM state encoding,
// the bit-stuffing run limit, the bus-idle recessive count and the default
// bit-timing parameters.
// ---------------------------------------------------------------------------
package can_pkg;

  // Equal consecutive bits after which the transmitter inserts a stuff bit.
  localparam int STUFF_LIMIT = 5;

  // Consecutive recessive samples that declare the bus idle.
  localparam int IDLE_BITS = 11;

  // Default bit timing: clocks per bit and the sample point within the bit.
  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_SAMPLE_POINT = 7;

  // Counter widths.
  localparam int RUN_W  = 3;
  localparam int IDLE_W = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_STUFF  = 2'd1,
    ST_ERROR  = 2'd2
  } destuff_state_e;

  // Saturating increment for the idle counter.
  function automatic logic [IDLE_W-1:0] idle_inc(input logic [IDLE_W-1:0] cnt);
    if (cnt >= IDLE_W'(IDLE_BITS)) begin
      return cnt;
    end
    return cnt + IDLE_W'(1);
  endfunction

endpackage

// File: rtl/can_bit_destuffer_if.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer_if
// Bus between the CAN receive front end / frame FSM and the bit destuffer.
//   Rx_Bit      raw bus level (0 = dominant, 1 = recessive)
//   Enable      stuffing region active (SOF through CRC sequence)
//   Clear       one-cycle frame restart
//   Bit_Out     destuffed data bit, valid while Bit_Valid = 1
//   Bit_Valid   one-cycle strobe per delivered (non-stuff) bit
//   Stuff_Error sticky stuffing violation flag
//   Bus_Idle    bus has been recessive for IDLE_BITS samples
// master: frame side (drives Rx_Bit/Enable/Clear); slave: destuffer.
// ---------------------------------------------------------------------------
interface can_bit_destuffer_if;

  logic Rx_Bit;
  logic Enable;
  logic Clear;
  logic Bit_Out;
  logic Bit_Valid;
  logic Stuff_Error;
  logic Bus_Idle;

  modport master (
    output Rx_Bit,
    output Enable,
    output Clear,
    input  Bit_Out,
    input  Bit_Valid,
    input  Stuff_Error,
    input  Bus_Idle
  );

  modport slave (
    input  Rx_Bit,
    input  Enable,
    input  Clear,
    output Bit_Out,
    output Bit_Valid,
    output Stuff_Error,
    output Bus_Idle
  );

endinterface

// File: rtl/can_bit_destuffer_bit_timer.sv
// ---------------------------------------------------------------------------
// can_bit_timer
// Bit-time counter for the CAN receiver. Counts 0..CLKS_PER_BIT-1 and wraps;
// tick_o is high for the one clock in which the count equals SAMPLE_POINT.
// While the bus is idle a recessive-to-dominant transition on rx_bit_i
// (previous clock vs current) hard-syncs the counter to 0 on the next edge.
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   rx_bit_i    raw bus level
//   bus_idle_i  bus idle status from the destuffer
//   tick_o      sample tick
// ---------------------------------------------------------------------------
module can_bit_timer
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = DEFAULT_SAMPLE_POINT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_bit_i,
  input  logic bus_idle_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             rx_prev_q;
  logic             hard_sync;

  // Only a falling edge seen from an idle bus is a start of frame.
  assign hard_sync = bus_idle_i && rx_prev_q && !rx_bit_i;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (hard_sync || (count_q == CNT_LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      rx_prev_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      rx_prev_q <= rx_bit_i;
    end
  end

  assign tick_o = (count_q == CNT_SAMPLE);

endmodule

// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
// CAN receive bit destuffer. Samples the bus once per bit time, removes stuff
// bits inside the stuffing region, flags stuffing violations and tracks bus
// idle. Outputs are registered one clock after the sample tick.
//   Clock_TB  system clock, rising edge
//   Reset     synchronous active-high reset
//   bus       slave side of can_bit_destuffer_if (Rx_Bit, Enable, Clear in;
//             Bit_Out, Bit_Valid, Stuff_Error, Bus_Idle out)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_NORMAL | delivering bits, counting equal consecutive bits
// ST_STUFF  | STUFF_LIMIT equal bits seen; next bit must be an opposite stuff
// ST_ERROR  | stuff bit missing; deliveries blocked until Clear or Reset
// ---------------------------------------------------------------------------
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SAMPLE_POINT = DEFAULT_SAMPLE_POINT
) (
  input  logic          Clock_TB,
  input  logic          Reset,
  can_bit_destuffer_if.slave bus
);

  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(STUFF_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_BITS);

  logic             tick;
  logic             sample;

  destuff_state_e   state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             last_q, last_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             stuff_err_q, stuff_err_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic             bus_idle;

  assign sample   = bus.Rx_Bit;
  assign bus_idle = (idle_q == IDLE_FULL);

  can_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_bit_timer (
    .clk_i      (Clock_TB),
    .rst_i      (Reset),
    .rx_bit_i   (bus.Rx_Bit),
    .bus_idle_i (bus_idle),
    .tick_o     (tick)
  );

  // Idle counter runs on every sample regardless of Clear or Enable.
  always_comb begin
    idle_d = idle_q;
    if (tick) begin
      if (sample) begin
        idle_d = idle_inc(idle_q);
      end else begin
        idle_d = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    last_d      = last_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    stuff_err_d = stuff_err_q;
    run_inc     = '0;

    if (bus.Clear) begin
      // Frame restart wins over a coincident tick; that bit is dropped.
      state_d     = ST_NORMAL;
      run_d       = '0;
      stuff_err_d = 1'b0;
    end else if (tick) begin
      if (!bus.Enable) begin
        // Outside the stuffing region bits pass straight through. run = 0
        // makes the first enabled bit start a fresh run of 1.
        bit_out_d   = sample;
        bit_valid_d = 1'b1;
        run_d       = '0;
        last_d      = sample;
        state_d     = ST_NORMAL;
      end else begin
        unique case (state_q)
          ST_NORMAL: begin
            run_inc     = (sample == last_q) ? (run_q + RUN_W'(1)) : RUN_W'(1);
            bit_out_d   = sample;
            bit_valid_d = 1'b1;
            run_d       = run_inc;
            last_d      = sample;
            if (run_inc == RUN_LIMIT) begin
              state_d = ST_STUFF;
            end
          end
          ST_STUFF: begin
            if (sample != last_q) begin
              // The stuff bit itself starts the next run.
              run_d   = RUN_W'(1);
              last_d  = sample;
              state_d = ST_NORMAL;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = ST_ERROR;
            end
          end
          ST_ERROR: begin
            state_d = ST_ERROR;
          end
          default: begin
            state_d = ST_NORMAL;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      state_q     <= ST_NORMAL;
      run_q       <= '0;
      last_q      <= 1'b1;
      bit_out_q   <= 1'b1;
      bit_valid_q <= 1'b0;
      stuff_err_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      last_q      <= last_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      stuff_err_q <= stuff_err_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.Bit_Out     = bit_out_q;
  assign bus.Bit_Valid   = bit_valid_q;
  assign bus.Stuff_Error = stuff_err_q;
  assign bus.Bus_Idle    = bus_idle;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_destuffer
// Directed bench for can_bit_destuffer. Bits are driven one bit time at a
// time, aligned to the DUT bit timer; a bit-level model predicts delivered
// bits, Stuff_Error and Bus_Idle, and a negedge process compares every cycle.
// ---------------------------------------------------------------------------
module tb_can_bit_destuffer;
  import can_pkg::*;

  localparam int CPB = 10;
  localparam int SP  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_bit_destuffer_if bus_if ();

  can_bit_destuffer #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_POINT (SP)
  ) dut (
    .Clock_TB (clk),
    .Reset    (rst),
    .bus      (bus_if)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   in_bit = 1'b0;

  // Model state: bits since the last run restart, sticky error, blocked
  // after a stuff violation, consecutive recessive samples.
  logic hist[$];
  logic exp_q[$];
  logic got[$];
  bit   m_err;
  bit   m_blocked;
  int   m_rec;
  bit   err_before, err_after, idle_before, idle_after;
  logic e_bit;

  logic pat_a [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic lit_a [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic pat_b [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic lit_b [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic int trailing_run();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_err     = 1'b0;
    m_blocked = 1'b0;
    m_rec     = 0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit time starting at a bit-timer zero. clr pulses Clear on the
  // sample-tick cycle.
  task automatic send_bit(input logic b, input logic en, input logic clr);
    err_before  = m_err;
    idle_before = (m_rec >= IDLE_BITS);
    m_rec = b ? m_rec + 1 : 0;
    if (clr) begin
      hist.delete();
      m_err     = 1'b0;
      m_blocked = 1'b0;
    end else if (!en) begin
      exp_q.push_back(b);
      hist.delete();
      m_blocked = 1'b0;
    end else if (!m_blocked) begin
      if (trailing_run() == STUFF_LIMIT) begin
        if (b != hist[hist.size() - 1]) begin
          hist.push_back(b);
        end else begin
          m_err     = 1'b1;
          m_blocked = 1'b1;
        end
      end else begin
        exp_q.push_back(b);
        hist.push_back(b);
      end
    end
    err_after  = m_err;
    idle_after = (m_rec >= IDLE_BITS);

    bus_if.Rx_Bit = b;
    bus_if.Enable = en;
    bus_if.Clear  = 1'b0;
    cyc    = 0;
    in_bit = 1'b1;
    for (int i = 1; i <= CPB; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      bus_if.Clear = (i == SP) ? clr : 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobe: got no Bit_Valid, expected Bit_Out=%b", exp_q[0]);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (in_bit) begin
      if (bus_if.Bit_Valid === 1'b1) begin
        got.push_back(bus_if.Bit_Out);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got Bit_Valid with Bit_Out=%b at bit cycle %0d, expected none",
                   bus_if.Bit_Out, cyc);
        end else begin
          e_bit = exp_q.pop_front();
          if (bus_if.Bit_Out !== e_bit) begin
            errors++;
            $display("FAIL bit_out: got %b, expected %b", bus_if.Bit_Out, e_bit);
          end
        end
        checks++;
        if (cyc != SP + 1) begin
          errors++;
          $display("FAIL strobe_timing: got strobe at bit cycle %0d, expected %0d", cyc, SP + 1);
        end
      end else if (bus_if.Bit_Valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL bit_valid_x: got %b, expected 0 or 1", bus_if.Bit_Valid);
      end
      checks++;
      if (bus_if.Stuff_Error !== ((cyc >= SP + 1) ? err_after : err_before)) begin
        errors++;
        $display("FAIL stuff_error: got %b, expected %b at bit cycle %0d", bus_if.Stuff_Error,
                 (cyc >= SP + 1) ? err_after : err_before, cyc);
      end
      checks++;
      if (bus_if.Bus_Idle !== ((cyc >= SP + 1) ? idle_after : idle_before)) begin
        errors++;
        $display("FAIL bus_idle: got %b, expected %b at bit cycle %0d", bus_if.Bus_Idle,
                 (cyc >= SP + 1) ? idle_after : idle_before, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.Rx_Bit = 1'b1;
    bus_if.Enable = 1'b0;
    bus_if.Clear  = 1'b0;
    rst = 1'b1;
    model_reset();
    hold(3);
    rst = 1'b0;

    check_bit("reset_bit_out", bus_if.Bit_Out, 1'b1);
    check_bit("reset_bit_valid", bus_if.Bit_Valid, 1'b0);
    check_bit("reset_stuff_error", bus_if.Stuff_Error, 1'b0);
    check_bit("reset_bus_idle", bus_if.Bus_Idle, 1'b0);

    // Disabled region: seven recessive bits pass through.
    got.delete();
    repeat (7) send_bit(1'b1, 1'b0, 1'b0);
    check_int("disabled_strobes", got.size(), 7);
    for (int i = 0; i < got.size(); i++) check_bit("disabled_bit", got[i], 1'b1);
    check_bit("disabled_no_error", bus_if.Stuff_Error, 1'b0);

    // Bus idle after the 11th recessive sample, then hard sync on SOF.
    repeat (3) send_bit(1'b1, 1'b0, 1'b0);
    check_bit("idle_after_10", bus_if.Bus_Idle, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check_bit("idle_after_11", bus_if.Bus_Idle, 1'b1);
    in_bit = 1'b0;
    hold(4);
    bus_if.Rx_Bit = 1'b0;
    bus_if.Enable = 1'b1;
    hold(1);
    got.delete();
    send_bit(1'b0, 1'b1, 1'b0);
    check_bit("idle_dropped", bus_if.Bus_Idle, 1'b0);
    check_int("sof_strobes", got.size(), 1);

    // Five zeros, stuff one, data one.
    send_bit(1'b1, 1'b0, 1'b0);
    got.delete();
    foreach (pat_a[i]) send_bit(pat_a[i], 1'b1, 1'b0);
    check_int("stuff0_strobes", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check_bit("stuff0_bit", got[i], lit_a[i]);
    check_bit("stuff0_no_error", bus_if.Stuff_Error, 1'b0);

    // Six zeros: stuff violation, sticky.
    send_bit(1'b1, 1'b0, 1'b0);
    got.delete();
    repeat (6) send_bit(1'b0, 1'b1, 1'b0);
    check_int("viol_strobes", got.size(), 5);
    check_bit("viol_error", bus_if.Stuff_Error, 1'b1);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    check_int("viol_blocked", got.size(), 5);
    check_bit("viol_sticky", bus_if.Stuff_Error, 1'b1);

    // Clear on a tick: bit dropped, error and run cleared.
    send_bit(1'b0, 1'b1, 1'b1);
    check_bit("clear_error", bus_if.Stuff_Error, 1'b0);
    got.delete();
    repeat (4) send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    repeat (5) send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    check_int("clear_run_strobes", got.size(), 10);
    check_bit("clear_run_no_error", bus_if.Stuff_Error, 1'b0);

    // Recessive run, stuff zero that starts the next dominant run.
    send_bit(1'b1, 1'b0, 1'b0);
    got.delete();
    foreach (pat_b[i]) send_bit(pat_b[i], 1'b1, 1'b0);
    check_int("stuff1_strobes", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) check_bit("stuff1_bit", got[i], lit_b[i]);
    check_bit("stuff1_no_error", bus_if.Stuff_Error, 1'b0);

    // Reset mid-bit while waiting for a stuff bit.
    send_bit(1'b1, 1'b0, 1'b0);
    repeat (5) send_bit(1'b0, 1'b1, 1'b0);
    in_bit = 1'b0;
    hold(3);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check_bit("midreset_bit_out", bus_if.Bit_Out, 1'b1);
    check_bit("midreset_bit_valid", bus_if.Bit_Valid, 1'b0);
    check_bit("midreset_stuff_error", bus_if.Stuff_Error, 1'b0);
    check_bit("midreset_bus_idle", bus_if.Bus_Idle, 1'b0);
    model_reset();
    got.delete();
    send_bit(1'b0, 1'b1, 1'b0);
    check_int("after_reset_strobes", got.size(), 1);
    if (got.size() > 0) check_bit("after_reset_bit", got[0], 1'b0);
    check_bit("after_reset_no_error", bus_if.Stuff_Error, 1'b0);
    in_bit = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
